// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 pipeline control path: icodes, status codes,
// the "no register" ID and the control FSM state type.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [3:0] S_AOK = 4'd1;
    localparam logic [3:0] S_HLT = 4'd2;
    localparam logic [3:0] S_ADR = 4'd3;
    localparam logic [3:0] S_INS = 4'd4;

    localparam logic [3:0] RNONE = 4'd15;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} ctrl_state_t;

    function automatic logic is_exc(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction
endpackage

// File: rtl/y86_pipe_ctrl_if.sv
// Stage fields in, pipeline-register controls and status/counters out.
// master = pipeline datapath side, slave = control unit.
interface y86_pipe_ctrl_if #(parameter int CNT_W = 16);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;
    logic             cnt_clr;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             cpu_halted;
    logic [3:0]       halt_code;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat, cnt_clr,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  cpu_halted, halt_code, stall_cnt, lu_cnt, mispred_cnt
    );
    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat, cnt_clr,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output cpu_halted, halt_code, stall_cnt, lu_cnt, mispred_cnt
    );
endinterface

// File: rtl/y86_pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;
endmodule

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection, sticky halt FSM and perf counters.
module y86_pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    y86_pipe_ctrl_if.slave  bus
);
    ctrl_state_t r_state;
    logic        r_halted;
    logic [3:0]  r_halt_code;

    logic w_load_use, w_ret_in, w_mispred, w_exc_m, w_exc_w, w_run;
    logic w_F_stall, w_D_stall, w_D_bubble, w_E_bubble, w_M_bubble, w_W_stall;
    logic [CNT_W-1:0] w_stall_cnt, w_lu_cnt, w_mispred_cnt;

    assign w_load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                        (bus.E_dstM != RNONE) &&
                        ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign w_ret_in   = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
    assign w_mispred  = (bus.E_icode == I_JXX) && !bus.e_Cnd;
    assign w_exc_m    = is_exc(bus.m_stat);
    assign w_exc_w    = is_exc(bus.W_stat);
    assign w_run      = (r_state == RUN);

    // Load/use wins over ret at D: the stalled instruction must stay in D, not be squashed.
    always_comb begin
        w_F_stall  = w_load_use | w_ret_in;
        w_D_stall  = w_load_use;
        w_D_bubble = w_mispred | (w_ret_in & !w_load_use);
        w_E_bubble = w_mispred | w_load_use;
        w_M_bubble = w_exc_m | w_exc_w;
        w_W_stall  = w_exc_w;
        if (!w_run) begin
            w_F_stall  = 1'b1;
            w_D_stall  = 1'b1;
            w_D_bubble = 1'b0;
            w_E_bubble = 1'b1;
            w_M_bubble = 1'b1;
            w_W_stall  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_halted    <= 1'b0;
            r_halt_code <= 4'd0;
        end else begin
            case (r_state)
                RUN: if (w_exc_w) begin
                    r_state     <= HALTED;
                    r_halted    <= 1'b1;
                    r_halt_code <= bus.W_stat;
                end
                HALTED: ;
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clr), .inc(w_run & w_F_stall), .count(w_stall_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_lu_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clr), .inc(w_run & w_load_use), .count(w_lu_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_mispred_cnt (
        .clk(clk), .rst(rst), .clr(bus.cnt_clr), .inc(w_run & w_mispred), .count(w_mispred_cnt)
    );

    assign bus.F_stall     = w_F_stall;
    assign bus.D_stall     = w_D_stall;
    assign bus.D_bubble    = w_D_bubble;
    assign bus.E_bubble    = w_E_bubble;
    assign bus.M_bubble    = w_M_bubble;
    assign bus.W_stall     = w_W_stall;
    assign bus.cpu_halted  = r_halted;
    assign bus.halt_code   = r_halt_code;
    assign bus.stall_cnt   = w_stall_cnt;
    assign bus.lu_cnt      = w_lu_cnt;
    assign bus.mispred_cnt = w_mispred_cnt;
endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Self-checking bench for y86_pipe_ctrl: vector table plus hand-written halt,
// ret-walk, counter and saturation sequences; expected controls go through a queue.
module tb_y86_pipe_ctrl;
    import y86_pkg::*;

    localparam int CNT_W = 16;

    typedef struct {
        logic [3:0] d_ic, sa, sb, e_ic, e_dm;
        logic       cnd;
        logic [3:0] m_ic, ms, ws;
        logic [5:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [5:0] exp_q[$];
    vec_t vecs[12];

    y86_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    y86_pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] d_ic, sa, sb, e_ic, e_dm, input logic cnd,
                                input logic [3:0] m_ic, ms, ws, input logic [5:0] exp);
        vec_t v;
        v.d_ic = d_ic; v.sa = sa; v.sb = sb; v.e_ic = e_ic; v.e_dm = e_dm;
        v.cnd = cnd; v.m_ic = m_ic; v.ms = ms; v.ws = ws; v.exp = exp;
        return v;
    endfunction

    function automatic logic [5:0] ctrl();
        return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one stimulus record and queue its expected control word.
    task automatic drive(input vec_t v);
        bus.D_icode = v.d_ic; bus.d_srcA = v.sa; bus.d_srcB = v.sb;
        bus.E_icode = v.e_ic; bus.E_dstM = v.e_dm; bus.e_Cnd = v.cnd;
        bus.M_icode = v.m_ic; bus.m_stat = v.ms; bus.W_stat = v.ws;
        exp_q.push_back(v.exp);
    endtask

    task automatic check_ctrl(input string name);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, {26'd0, ctrl()}, {26'd0, e});
        end
    endtask

    // One cycle: drive after the rising edge, check on the falling edge.
    task automatic step(input vec_t v, input string name);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check_ctrl(name);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(I_NOP, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b000000));
        @(negedge clk);
        check_ctrl("reset_ctrl");
        rst = 1'b0;
    endtask

    vec_t idle;

    initial begin
        idle = mk(I_NOP, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b000000);
        vecs[0]  = idle;
        vecs[1]  = mk(I_NOP, 4'd3, RNONE, I_MRMOVQ, 4'd3, 1'b1, I_NOP, S_AOK, S_AOK, 6'b110100);
        vecs[2]  = mk(I_NOP, RNONE, RNONE, I_POPQ, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b000000);
        vecs[3]  = mk(I_NOP, 4'd1, 4'd4, I_POPQ, 4'd4, 1'b1, I_NOP, S_AOK, S_AOK, 6'b110100);
        vecs[4]  = mk(I_NOP, 4'd2, 4'd5, I_MRMOVQ, 4'd3, 1'b1, I_NOP, S_AOK, S_AOK, 6'b000000);
        vecs[5]  = mk(I_RET, RNONE, RNONE, I_JXX, RNONE, 1'b0, I_NOP, S_AOK, S_AOK, 6'b101100);
        vecs[6]  = mk(I_NOP, RNONE, RNONE, I_JXX, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b000000);
        vecs[7]  = mk(I_RET, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b101000);
        vecs[8]  = mk(I_RET, 4'd2, RNONE, I_MRMOVQ, 4'd2, 1'b1, I_NOP, S_AOK, S_AOK, 6'b110100);
        vecs[9]  = mk(I_NOP, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_NOP, S_ADR, S_AOK, 6'b000010);
        vecs[10] = mk(I_NOP, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_RET, S_INS, S_AOK, 6'b101010);
        vecs[11] = mk(I_NOP, RNONE, RNONE, I_JXX, RNONE, 1'b0, I_RET, S_AOK, S_AOK, 6'b101100);

        bus.cnt_clr = 1'b0;
        drive(idle);
        void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_halted", {31'd0, bus.cpu_halted}, 32'd0);
        chk("rst_code", {28'd0, bus.halt_code}, 32'd0);
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        chk("rst_lu_cnt", {16'd0, bus.lu_cnt}, 32'd0);
        chk("rst_mp_cnt", {16'd0, bus.mispred_cnt}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Load/use counted once, visible the following cycle.
        do_reset();
        step(vecs[1], "lu_ctrl");
        step(idle, "lu_idle");
        chk("lu_cnt", {16'd0, bus.lu_cnt}, 32'd1);
        chk("lu_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);

        // Mispredict with ret in D.
        do_reset();
        step(vecs[5], "mp_ctrl");
        step(idle, "mp_idle");
        chk("mp_cnt", {16'd0, bus.mispred_cnt}, 32'd1);
        chk("mp_lu_cnt", {16'd0, bus.lu_cnt}, 32'd0);

        // ret walking D -> E -> M.
        do_reset();
        step(mk(I_RET, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b101000), "ret_D");
        step(mk(I_NOP, RNONE, RNONE, I_RET, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 6'b101000), "ret_E");
        step(mk(I_NOP, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_RET, S_AOK, S_AOK, 6'b101000), "ret_M");
        step(idle, "ret_idle");
        chk("ret_stall_cnt", {16'd0, bus.stall_cnt}, 32'd3);

        // Exception retires with a load/use hazard in the same cycle.
        do_reset();
        step(mk(I_NOP, RNONE, RNONE, I_NOP, RNONE, 1'b1, I_NOP, S_ADR, S_AOK, 6'b000010), "halt_m");
        chk("halt_m_halted", {31'd0, bus.cpu_halted}, 32'd0);
        step(mk(I_NOP, 4'd3, RNONE, I_MRMOVQ, 4'd3, 1'b1, I_NOP, S_AOK, S_ADR, 6'b110111), "halt_w");
        chk("halt_w_halted", {31'd0, bus.cpu_halted}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            vec_t r;
            r = mk(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 6'b110111);
            step(r, $sformatf("halted_rand%0d", i));
            if (i == 0 || i == 19) begin
                chk("halted_flag", {31'd0, bus.cpu_halted}, 32'd1);
                chk("halted_code", {28'd0, bus.halt_code}, 32'd3);
            end
        end
        chk("frz_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        chk("frz_lu_cnt", {16'd0, bus.lu_cnt}, 32'd1);
        chk("frz_mp_cnt", {16'd0, bus.mispred_cnt}, 32'd0);

        // Asynchronous reset out of HALTED; controls follow RUN equations meanwhile.
        @(posedge clk); #2;
        rst = 1'b1;
        drive(vecs[1]);
        #1;
        chk("arst_halted", {31'd0, bus.cpu_halted}, 32'd0);
        chk("arst_code", {28'd0, bus.halt_code}, 32'd0);
        chk("arst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        chk("arst_lu_cnt", {16'd0, bus.lu_cnt}, 32'd0);
        @(negedge clk);
        check_ctrl("arst_ctrl");
        rst = 1'b0;

        // Saturation then clear.
        do_reset();
        @(posedge clk); #1;
        drive(vecs[7]);
        void'(exp_q.pop_front());
        repeat ((1 << CNT_W) + 5) @(posedge clk);
        @(negedge clk);
        chk("sat_stall_cnt", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        chk("sat_lu_cnt", {16'd0, bus.lu_cnt}, 32'd0);
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        chk("clr_halted", {31'd0, bus.cpu_halted}, 32'd0);
        @(negedge clk);
        chk("post_clr_cnt", {16'd0, bus.stall_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/y86_pipe_ctrl.md
# y86_pipe_ctrl

Pipeline control unit for the 5-stage Y86-64 core. Each cycle it evaluates load/use, `ret` and branch-mispredict hazards from the D, E, M and W stage fields, and drives the stall and bubble controls of the F, D, E, M and W pipeline registers. It holds a sticky RUN/HALTED state machine that freezes the pipe once an exception status retires. It also keeps saturating performance counters for stalls, load/use bubbles and mispredicts.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- D_icode  in  4  icode in D register
- d_srcA  in  4  decode source A register ID (15 = none)
- d_srcB  in  4  decode source B register ID (15 = none)
- E_icode  in  4  icode in E register
- E_dstM  in  4  memory-destination register ID in E register
- e_Cnd  in  1  condition result computed in execute
- M_icode  in  4  icode in M register
- m_stat  in  4  status produced by memory stage
- W_stat  in  4  status in W register
- cnt_clr  in  1  synchronous clear of all counters
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline register controls
- cpu_halted  out  1  registered, 1 while in HALTED
- halt_code  out  4  W_stat captured on entry to HALTED
- stall_cnt, lu_cnt, mispred_cnt  out  CNT_W each  performance counters

## Operation
- Encodings: icode JXX=7, MRMOVQ=5, RET=9, POPQ=11. Stat AOK=1, HLT=2, ADR=3, INS=4. RNONE=15.
- load_use = (E_icode is MRMOVQ or POPQ) and E_dstM != RNONE and E_dstM equals d_srcA or d_srcB.
- ret_in = RET in any of D_icode, E_icode, M_icode.
- mispred = (E_icode == JXX) and !e_Cnd.
- exc_m = m_stat in {HLT, ADR, INS}. exc_w = W_stat in {HLT, ADR, INS}.
- RUN outputs:
  - F_stall = load_use | ret_in
  - D_stall = load_use
  - D_bubble = mispred | (ret_in & !load_use)
  - E_bubble = mispred | load_use
  - M_bubble = exc_m | exc_w
  - W_stall = exc_w
- HALTED outputs: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0. These values hold regardless of inputs.
- FSM transitions:
  - RUN->HALTED at the clock edge where exc_w=1; halt_code <= W_stat on that edge.
  - HALTED is left only by rst.
- Counters advance only in RUN, at the clock edge, each saturating at all-ones (no wrap):
  - stall_cnt +1 on each cycle with F_stall=1
  - lu_cnt +1 on each cycle with load_use=1
  - mispred_cnt +1 on each cycle with mispred=1
- cnt_clr has priority over increment; it clears counters only. State and halt_code are unaffected.
- Simultaneous events:
  - mispred with ret in D: D_bubble=1, E_bubble=1, F_stall=1.
  - load_use with ret in D: D_stall=1, D_bubble=0.
  - exc_w in the same cycle as a hazard: RUN equations apply that cycle, HALTED values from the next cycle.

## Timing
- Hazard outputs are combinational from the current inputs and state, with zero-cycle latency.
- cpu_halted and halt_code update one edge after exc_w is seen.
- Counter values are visible the cycle after the counted event.
- Reset values (asynchronous, immediate on rst assertion): state=RUN, cpu_halted=0, halt_code=0, all counters 0.
- While rst=1, the hazard outputs follow the RUN equations.
- Reset asserted mid-operation (including in HALTED) returns the block to RUN with no residual state.

## Structure
- Shared package y86_pkg holds:
  - icode constants (JXX, MRMOVQ, RET, POPQ, etc.)
  - stat codes AOK/HLT/ADR/INS
  - RNONE
  - the state enum RUN/HALTED
- One sub-module, sat_counter (params WIDTH; ports clk, rst, clr, inc, count). It is instantiated three times.
- Hazard equations, FSM and halt_code register live in the top module.

## Test plan
- Load/use: E_icode=5, E_dstM=3, d_srcA=3. Expect F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. lu_cnt reads 1 next cycle.
- RNONE guard: E_icode=11, E_dstM=15, d_srcB=15. Expect all controls 0.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=9. Expect D_bubble=1, E_bubble=1, F_stall=1. mispred_cnt reads 1 next cycle.
- ret: RET walks through D, E, M over 3 cycles with no load/use. Expect F_stall=1 and D_bubble=1 on each of the 3 cycles; stall_cnt reads 3 afterward.
- Halt:
  - m_stat=3 gives M_bubble=1 with cpu_halted still 0.
  - Next cycle W_stat=3 gives W_stall=1.
  - After that edge, cpu_halted=1, halt_code=3, and the HALTED output values hold under random inputs.
  - Counters are frozen; rst returns everything to 0.
- Saturation/clear: preload stall_cnt by forcing F_stall for 2^CNT_W+5 cycles. Expect all-ones. Assert cnt_clr together with F_stall; expect 0 next cycle.
